// File: rtl/atomicity_monitor_mr_pkg.sv
// Shared state/cause encodings and region address helper for the multi-region atomicity monitor.
package atomicity_pkg;

    typedef enum logic [2:0] {
        ST_NOT_RC = 3'd0,
        ST_FST    = 3'd1,
        ST_MID    = 3'd2,
        ST_LAST   = 3'd3,
        ST_KILL   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_ENTRY = 2'd1,
        CAUSE_EXIT  = 2'd2,
        CAUSE_IRQ   = 2'd3
    } cause_t;

    localparam logic [7:0] COUNT_MAX  = 8'hFF;
    localparam int         MAX_ADDR_W = 32;

    // Address of the final instruction slot in a region (code is 16-bit aligned).
    function automatic logic [MAX_ADDR_W-1:0] LAST_ADDR(input logic [MAX_ADDR_W-1:0] base,
                                                         input logic [MAX_ADDR_W-1:0] size);
        return base + size - 32'd2;
    endfunction

endpackage

// File: rtl/atomicity_monitor_mr_if.sv
// PC/IRQ observation bus and reset/diagnostic return path between CPU-side and the monitor.
interface atomicity_monitor_mr_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic              pc_en;
    logic              irq;
    logic              reset;
    logic [1:0]        viol_cause;
    logic [1:0]        viol_region;
    logic [7:0]        viol_count;

    modport master (
        output pc, pc_en, irq,
        input  reset, viol_cause, viol_region, viol_count
    );

    modport slave (
        input  pc, pc_en, irq,
        output reset, viol_cause, viol_region, viol_count
    );
endinterface

// File: rtl/atomicity_monitor_mr_region_dec.sv
// Classifies the current PC against one protected region: first, middle, last, or anywhere inside.
module atomicity_region_dec
    import atomicity_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_size,
    output logic              o_first,
    output logic              o_mid,
    output logic              o_last,
    output logic              o_in
);
    logic [ADDR_W-1:0] w_last_addr;

    assign w_last_addr = ADDR_W'(LAST_ADDR(MAX_ADDR_W'(i_base), MAX_ADDR_W'(i_size)));

    assign o_first = (i_pc == i_base);
    assign o_last  = (i_pc == w_last_addr);
    assign o_in    = (i_pc >= i_base) && (i_pc <= w_last_addr);
    assign o_mid   = o_in && !o_first && !o_last;
endmodule

// File: rtl/atomicity_monitor_mr.sv
// Multi-region atomicity monitor: enforces entry at first / exit from last address, optional IRQ
// lockout, and raises a zero-latency reset request with sticky violation diagnostics.
module atomicity_monitor_mr
    import atomicity_pkg::*;
#(
    parameter int                            ADDR_W        = 16,
    parameter int                            NUM_REGIONS   = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE   = {16'hE000, 16'hA000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE   = {16'h1000, 16'h4000},
    parameter logic [ADDR_W-1:0]             RESET_HANDLER = 16'hFFFE,
    parameter bit                            IRQ_KILL      = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    atomicity_monitor_mr_if.slave bus
);
    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_cur;
    logic [1:0]       w_next_cur;
    cause_t           r_cause;
    cause_t           w_viol_cause;
    logic [1:0]       r_region;
    logic [1:0]       w_viol_region;
    logic [7:0]       r_count;

    logic [NUM_REGIONS-1:0] w_first;
    logic [NUM_REGIONS-1:0] w_mid;
    logic [NUM_REGIONS-1:0] w_last;
    logic [NUM_REGIONS-1:0] w_in;

    logic       w_any_in;
    logic [1:0] w_hit;
    logic       w_hit_first;
    logic       w_cur_first;
    logic       w_cur_mid;
    logic       w_cur_last;
    logic       w_cur_in;
    logic       w_at_handler;
    logic       w_irq_kill;
    logic       w_viol_now;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        atomicity_region_dec #(
            .ADDR_W (ADDR_W)
        ) u_dec (
            .i_pc    (bus.pc),
            .i_base  (REGION_BASE[g*ADDR_W +: ADDR_W]),
            .i_size  (REGION_SIZE[g*ADDR_W +: ADDR_W]),
            .o_first (w_first[g]),
            .o_mid   (w_mid[g]),
            .o_last  (w_last[g]),
            .o_in    (w_in[g])
        );
    end

    // Scan downward so the lowest-index region wins if regions ever overlap.
    always_comb begin
        w_any_in    = 1'b0;
        w_hit       = 2'd0;
        w_hit_first = 1'b0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if (w_in[k]) begin
                w_any_in    = 1'b1;
                w_hit       = 2'(k);
                w_hit_first = w_first[k];
            end
        end
    end

    always_comb begin
        w_cur_first = 1'b0;
        w_cur_mid   = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_in    = 1'b0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (r_cur == 2'(k)) begin
                w_cur_first = w_first[k];
                w_cur_mid   = w_mid[k];
                w_cur_last  = w_last[k];
                w_cur_in    = w_in[k];
            end
        end
    end

    assign w_at_handler = (bus.pc == RESET_HANDLER);
    assign w_irq_kill   = IRQ_KILL && bus.irq && w_cur_in &&
                          (r_state inside {ST_FST, ST_MID, ST_LAST});

    always_comb begin
        w_next_state  = r_state;
        w_next_cur    = r_cur;
        w_viol_cause  = CAUSE_NONE;
        w_viol_region = r_cur;
        if (bus.pc_en) begin
            if (w_irq_kill) begin
                w_next_state = ST_KILL;
                w_viol_cause = CAUSE_IRQ;
            end else begin
                case (r_state)
                    ST_NOT_RC: begin
                        if (w_any_in && w_hit_first) begin
                            w_next_state = ST_FST;
                            w_next_cur   = w_hit;
                        end else if (w_any_in) begin
                            w_next_state  = ST_KILL;
                            w_viol_cause  = CAUSE_ENTRY;
                            w_viol_region = w_hit;
                        end
                    end
                    ST_FST: begin
                        if (w_cur_mid) begin
                            w_next_state = ST_MID;
                        end else if (!w_cur_first) begin
                            w_next_state = ST_KILL;
                            w_viol_cause = CAUSE_EXIT;
                        end
                    end
                    ST_MID: begin
                        if (w_cur_last) begin
                            w_next_state = ST_LAST;
                        end else if (!w_cur_mid) begin
                            w_next_state = ST_KILL;
                            w_viol_cause = CAUSE_EXIT;
                        end
                    end
                    ST_LAST: begin
                        if (w_cur_last) begin
                            w_next_state = ST_LAST;
                        end else if (!w_any_in) begin
                            w_next_state = ST_NOT_RC;
                        end else if (w_hit_first && (w_hit != r_cur)) begin
                            // Back-to-back regions: leaving one at its last slot may enter the next.
                            w_next_state = ST_FST;
                            w_next_cur   = w_hit;
                        end else begin
                            w_next_state = ST_KILL;
                            w_viol_cause = CAUSE_EXIT;
                        end
                    end
                    ST_KILL: begin
                        if (w_at_handler) begin
                            w_next_state = ST_NOT_RC;
                        end
                    end
                    default: begin
                        w_next_state = ST_KILL;
                    end
                endcase
            end
        end
    end

    assign w_viol_now = bus.pc_en && (w_next_state == ST_KILL) && (r_state != ST_KILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_KILL;
            r_cur   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cur   <= w_next_cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause  <= CAUSE_NONE;
            r_region <= 2'd0;
            r_count  <= 8'd0;
        end else if (w_viol_now) begin
            r_cause  <= w_viol_cause;
            r_region <= w_viol_region;
            if (r_count != COUNT_MAX) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.reset       = w_viol_now || ((r_state == ST_KILL) && !w_at_handler);
    assign bus.viol_cause  = r_cause;
    assign bus.viol_region = r_region;
    assign bus.viol_count  = r_count;
endmodule

// File: tb/tb_atomicity_monitor_mr.sv
// Self-checking bench for atomicity_monitor_mr: directed vector table, corner sequences,
// and randomized traffic against a range/position based reference model.
module tb_atomicity_monitor_mr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = 16'h0200;
    logic        pcEn = 1'b0;
    logic        irq = 1'b0;

    int checks = 0;
    int errors = 0;

    atomicity_monitor_mr_if #(.ADDR_W(16)) busA ();
    atomicity_monitor_mr_if #(.ADDR_W(16)) busB ();

    assign busA.pc    = pc;
    assign busA.pc_en = pcEn;
    assign busA.irq   = irq;
    assign busB.pc    = pc;
    assign busB.pc_en = pcEn;
    assign busB.irq   = irq;

    atomicity_monitor_mr #(
        .ADDR_W        (16),
        .NUM_REGIONS   (2),
        .REGION_BASE   (32'hE000_A000),
        .REGION_SIZE   (32'h1000_4000),
        .RESET_HANDLER (16'hFFFE),
        .IRQ_KILL      (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    atomicity_monitor_mr #(
        .ADDR_W        (16),
        .NUM_REGIONS   (2),
        .REGION_BASE   (32'hE000_A000),
        .REGION_SIZE   (32'h1000_4000),
        .RESET_HANDLER (16'hFFFE),
        .IRQ_KILL      (1'b0)
    ) dutNoIrq (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: position within the current region (-1 outside, 0 first, 1 middle, 2 last)
    int mPos;
    int mCur;
    bit mKilled;
    int mCause;
    int mRegion;
    int mCount;

    function automatic int baseOf(input int k);
        return (k == 0) ? 32'hA000 : 32'hE000;
    endfunction

    function automatic int lastOf(input int k);
        return baseOf(k) + ((k == 0) ? 32'h4000 : 32'h1000) - 2;
    endfunction

    function automatic void locate(input logic [15:0] a, output int region, output int pos);
        int ai;
        ai     = int'(a);
        region = -1;
        pos    = -1;
        for (int k = 1; k >= 0; k--) begin
            if (ai >= baseOf(k) && ai <= lastOf(k)) begin
                region = k;
                pos    = (ai == baseOf(k)) ? 0 : ((ai == lastOf(k)) ? 2 : 1);
            end
        end
    endfunction

    function automatic void predict(input logic [15:0] a, input logic en, input logic irqIn,
                                    output bit viol, output int cause, output int region,
                                    output bit nKilled, output int nPos, output int nCur);
        int r;
        int p;
        locate(a, r, p);
        viol    = 1'b0;
        cause   = 0;
        region  = mCur;
        nKilled = mKilled;
        nPos    = mPos;
        nCur    = mCur;
        if (!en) return;
        if (mKilled) begin
            if (a == 16'hFFFE) begin
                nKilled = 1'b0;
                nPos    = -1;
            end
            return;
        end
        if (mPos >= 0 && irqIn && r == mCur) begin
            viol = 1'b1; cause = 3;
        end else if (mPos < 0) begin
            if (r >= 0 && p == 0) begin
                nPos = 0; nCur = r;
            end else if (r >= 0) begin
                viol = 1'b1; cause = 1; region = r;
            end
        end else if (r == mCur && (p == mPos || p == mPos + 1)) begin
            nPos = p;
        end else if (mPos == 2 && r < 0) begin
            nPos = -1;
        end else if (mPos == 2 && p == 0 && r != mCur) begin
            nPos = 0; nCur = r;
        end else begin
            viol = 1'b1; cause = 2;
        end
        if (viol) nKilled = 1'b1;
    endfunction

    task automatic modelReset();
        mKilled = 1'b1;
        mPos    = -1;
        mCur    = 0;
        mCause  = 0;
        mRegion = 0;
        mCount  = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic en, input logic irqv);
        pc   = a;
        pcEn = en;
        irq  = irqv;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        pc = 16'h0200; pcEn = 1'b1; irq = 1'b0;
        #2;
        checkOutput("rst_reset", 32'(busA.reset), 32'd1);
        checkOutput("rst_cause", 32'(busA.viol_cause), 32'd0);
        checkOutput("rst_region", 32'(busA.viol_region), 32'd0);
        checkOutput("rst_count", 32'(busA.viol_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic modelStep(input logic [15:0] a, input logic en, input logic irqv);
        bit viol;
        bit nK;
        int cause;
        int region;
        int nPos;
        int nCur;
        applyStimulus(a, en, irqv);
        predict(a, en, irqv, viol, cause, region, nK, nPos, nCur);
        checkOutput("m_reset", 32'(busA.reset), (viol || (mKilled && a != 16'hFFFE)) ? 32'd1 : 32'd0);
        tick();
        if (viol) begin
            mCause  = cause;
            mRegion = region;
            if (mCount < 255) mCount++;
        end
        mKilled = nK;
        mPos    = nPos;
        mCur    = nCur;
        checkOutput("m_cause", 32'(busA.viol_cause), 32'(mCause));
        checkOutput("m_region", 32'(busA.viol_region), 32'(mRegion));
        checkOutput("m_count", 32'(busA.viol_count), 32'(mCount));
    endtask

    function automatic logic [15:0] pickPc(input logic [15:0] prev);
        logic [15:0] r0Mid;
        logic [15:0] r1Mid;
        logic [15:0] outside;
        int          other;
        r0Mid   = 16'hA002 + 16'(2 * $urandom_range(0, 32'h1FFD));
        r1Mid   = 16'hE002 + 16'(2 * $urandom_range(0, 32'h07FD));
        outside = 16'(2 * $urandom_range(0, 32'h4FFF));
        case ($urandom_range(0, 11))
            0: return 16'hFFFE;
            1: return 16'hA000;
            2: return 16'hDFFE;
            3: return 16'hE000;
            4: return 16'hEFFE;
            5: return r0Mid;
            6: return r1Mid;
            7: return outside;
            8: return prev;
            9: return 16'($urandom());
            default: begin
                if (mKilled) return 16'hFFFE;
                if (mPos < 0) return ($urandom_range(0, 1) == 0) ? 16'hA000 : 16'hE000;
                if (mPos < 2) begin
                    if ($urandom_range(0, 3) == 0) return 16'(lastOf(mCur));
                    return (mCur == 0) ? r0Mid : r1Mid;
                end
                other = 1 - mCur;
                return ($urandom_range(0, 1) == 0) ? outside : 16'(baseOf(other));
            end
        endcase
    endfunction

    typedef struct {
        logic [15:0] pc;
        logic        en;
        logic        irq;
        logic        expReset;
        logic [1:0]  expCause;
        logic [1:0]  expRegion;
        logic [7:0]  expCount;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [15:0] a, input logic en, input logic irqv, input logic rs,
                          input logic [1:0] c, input logic [1:0] r, input logic [7:0] n);
        vec_t v;
        v.pc = a; v.en = en; v.irq = irqv;
        v.expReset = rs; v.expCause = c; v.expRegion = r; v.expCount = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] prev;

        // pc, en, irq | reset | cause, region, count after the edge
        addVec(16'hFFFE, 1, 0, 0, 0, 0, 0);
        addVec(16'hA000, 1, 0, 0, 0, 0, 0);
        addVec(16'hA002, 1, 0, 0, 0, 0, 0);
        addVec(16'hDFFE, 1, 0, 0, 0, 0, 0);
        addVec(16'hE000, 1, 0, 0, 0, 0, 0);
        addVec(16'hE100, 1, 0, 0, 0, 0, 0);
        addVec(16'h0300, 1, 0, 1, 2, 1, 1);
        addVec(16'h0300, 1, 0, 1, 2, 1, 1);
        addVec(16'hFFFE, 1, 0, 0, 2, 1, 1);
        addVec(16'hA010, 0, 0, 0, 2, 1, 1);
        addVec(16'hA010, 1, 0, 1, 1, 0, 2);
        addVec(16'h1234, 1, 0, 1, 1, 0, 2);
        addVec(16'hFFFE, 0, 0, 0, 1, 0, 2);
        addVec(16'h1234, 1, 0, 1, 1, 0, 2);
        addVec(16'hFFFE, 1, 0, 0, 1, 0, 2);
        addVec(16'hA000, 1, 0, 0, 1, 0, 2);
        addVec(16'hA000, 1, 0, 0, 1, 0, 2);
        addVec(16'hA004, 1, 0, 0, 1, 0, 2);
        addVec(16'hA004, 1, 1, 1, 3, 0, 3);
        addVec(16'hFFFE, 1, 0, 0, 3, 0, 3);
        addVec(16'hA000, 1, 0, 0, 3, 0, 3);
        addVec(16'hDFFE, 1, 0, 1, 2, 0, 4);
        addVec(16'hFFFE, 1, 0, 0, 2, 0, 4);
        addVec(16'hE000, 1, 0, 0, 2, 0, 4);
        addVec(16'hE002, 1, 0, 0, 2, 0, 4);
        addVec(16'hEFFE, 1, 0, 0, 2, 0, 4);
        addVec(16'h0200, 1, 0, 0, 2, 0, 4);
        addVec(16'h0202, 1, 0, 0, 2, 0, 4);
        addVec(16'hDFFE, 1, 0, 1, 1, 0, 5);
        addVec(16'hFFFE, 1, 0, 0, 1, 0, 5);
        addVec(16'hE000, 1, 0, 0, 1, 0, 5);
        addVec(16'hE002, 1, 0, 0, 1, 0, 5);
        addVec(16'hEFFE, 1, 0, 0, 1, 0, 5);
        addVec(16'hEFFE, 1, 0, 0, 1, 0, 5);
        addVec(16'hE000, 1, 0, 1, 2, 1, 6);
        addVec(16'hFFFE, 1, 0, 0, 2, 1, 6);
        addVec(16'hA000, 1, 0, 0, 2, 1, 6);
        addVec(16'hA002, 1, 0, 0, 2, 1, 6);
        addVec(16'hA002, 0, 1, 0, 2, 1, 6);
        addVec(16'hA002, 1, 1, 1, 3, 0, 7);
        addVec(16'hFFFE, 1, 0, 0, 3, 0, 7);
        addVec(16'hA000, 1, 0, 0, 3, 0, 7);
        addVec(16'hA100, 1, 0, 0, 3, 0, 7);
        addVec(16'hDFFE, 1, 0, 0, 3, 0, 7);
        addVec(16'hE010, 1, 0, 1, 2, 0, 8);
        addVec(16'hFFFE, 1, 0, 0, 2, 0, 8);
        addVec(16'hA000, 1, 0, 0, 2, 0, 8);
        addVec(16'hA100, 1, 0, 0, 2, 0, 8);
        addVec(16'hDFFE, 1, 0, 0, 2, 0, 8);
        addVec(16'h0200, 1, 1, 0, 2, 0, 8);
        addVec(16'h0200, 1, 1, 0, 2, 0, 8);
        addVec(16'hA000, 1, 0, 0, 2, 0, 8);
        addVec(16'hA002, 1, 0, 0, 2, 0, 8);
        addVec(16'hA000, 1, 0, 1, 2, 0, 9);
        addVec(16'hFFFE, 1, 0, 0, 2, 0, 9);

        #1;
        resetDut();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pc, vecs[i].en, vecs[i].irq);
            checkOutput($sformatf("vec%0d_reset", i), 32'(busA.reset), 32'(vecs[i].expReset));
            tick();
            checkOutput($sformatf("vec%0d_cause", i), 32'(busA.viol_cause), 32'(vecs[i].expCause));
            checkOutput($sformatf("vec%0d_region", i), 32'(busA.viol_region), 32'(vecs[i].expRegion));
            checkOutput($sformatf("vec%0d_count", i), 32'(busA.viol_count), 32'(vecs[i].expCount));
        end

        // Full walk through region 0 after reset, leaving cleanly, then proving NOT_RC by an entry fault
        resetDut();
        applyStimulus(16'h0200, 1, 0);
        checkOutput("walk_kill_held", 32'(busA.reset), 32'd1);
        tick();
        modelStep(16'hFFFE, 1, 0);
        modelStep(16'hA000, 1, 0);
        for (int a = 32'hA002; a <= 32'hDFFC; a += 2) modelStep(16'(a), 1, 0);
        modelStep(16'hDFFE, 1, 0);
        modelStep(16'h0200, 1, 0);
        checkOutput("walk_count", 32'(busA.viol_count), 32'd0);
        modelStep(16'hA010, 1, 0);
        checkOutput("walk_entry_cause", 32'(busA.viol_cause), 32'd1);
        checkOutput("walk_entry_count", 32'(busA.viol_count), 32'd1);

        // IRQ inside a region: only the IRQ_KILL=1 instance reacts
        resetDut();
        modelStep(16'hFFFE, 1, 0);
        modelStep(16'hA000, 1, 0);
        modelStep(16'hA004, 1, 0);
        applyStimulus(16'hA004, 1, 1);
        checkOutput("irq_reset_kill", 32'(busA.reset), 32'd1);
        checkOutput("irq_reset_nokill", 32'(busB.reset), 32'd0);
        tick();
        checkOutput("irq_cause_kill", 32'(busA.viol_cause), 32'd3);
        checkOutput("irq_cause_nokill", 32'(busB.viol_cause), 32'd0);
        checkOutput("irq_count_nokill", 32'(busB.viol_count), 32'd0);

        // Asynchronous reset in the middle of a region clears diagnostics without a clock edge
        resetDut();
        modelStep(16'hFFFE, 1, 0);
        modelStep(16'hA000, 1, 0);
        modelStep(16'h0300, 1, 0);
        modelStep(16'hFFFE, 1, 0);
        modelStep(16'hA000, 1, 0);
        modelStep(16'hA004, 1, 0);
        applyStimulus(16'hA006, 1, 0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_reset", 32'(busA.reset), 32'd1);
        checkOutput("async_rst_cause", 32'(busA.viol_cause), 32'd0);
        checkOutput("async_rst_count", 32'(busA.viol_count), 32'd0);
        tick();

        // Saturating violation counter
        resetDut();
        for (int i = 0; i < 300; i++) begin
            modelStep(16'hFFFE, 1, 0);
            modelStep(16'hA010, 1, 0);
        end
        checkOutput("count_saturated", 32'(busA.viol_count), 32'd255);

        // Randomized traffic against the reference model
        resetDut();
        prev = 16'h0200;
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] a;
            a = pickPc(prev);
            modelStep(a, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
            prev = a;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
